// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: source encoding,
// RegWEn format codes and the data/index widths.
package regfile_wb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } src_t;

    localparam logic [2:0] WEN_NONE = 3'b000;
    localparam logic [2:0] WEN_W    = 3'b001;
    localparam logic [2:0] WEN_B    = 3'b010;
    localparam logic [2:0] WEN_H    = 3'b011;
    localparam logic [2:0] WEN_BU   = 3'b100;
    localparam logic [2:0] WEN_HU   = 3'b101;

    // A load reporting "no format" still has to write a full word.
    function automatic logic [2:0] mapFmt(input logic [2:0] fmt);
        return (fmt == WEN_NONE) ? WEN_W : fmt;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback sources, decode hazard query and register-file
// write port seen by the arbiter.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic [2:0]        lsu_fmt;

    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_AW-1:0] mdu_rd;
    logic [XLEN-1:0]   mdu_data;

    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;

    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic              stall;

    logic [2:0]        RegWEn;
    logic [REG_AW-1:0] WriteAddress;
    logic [XLEN-1:0]   WriteData;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, lsu_fmt,
        input  mdu_valid, mdu_rd, mdu_data,
        input  issue_valid, issue_rd,
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        output lsu_ready, mdu_ready, stall,
        output RegWEn, WriteAddress, WriteData
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, lsu_fmt,
        output mdu_valid, mdu_rd, mdu_data,
        output issue_valid, issue_rd,
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  lsu_ready, mdu_ready, stall,
        input  RegWEn, WriteAddress, WriteData
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant between request A and request B, suppressed
// entirely while a higher-priority requester blocks the port.
module wb_rr_arb2 (
    input  logic CLK,
    input  logic rst_n,
    input  logic block,
    input  logic reqA,
    input  logic reqB,
    output logic grantA,
    output logic grantB
);

    logic rrReg;
    logic rrNext;

    // rrReg=0 favours A on a tie, rrReg=1 favours B.
    assign grantA = ~block & reqA & (~reqB | ~rrReg);
    assign grantB = ~block & reqB & (~reqA | rrReg);

    always_comb begin
        rrNext = rrReg;
        if (grantA) begin
            rrNext = 1'b1;
        end else if (grantB) begin
            rrNext = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rrReg <= 1'b0;
        end else begin
            rrReg <= rrNext;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter (ALU > round-robin LSU/MDU) with a
// pending-write scoreboard that stalls decode on long-latency hazards.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 CLK,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic              lsuGrant;
    logic              mduGrant;

    logic              winValid;
    logic              winLong;
    logic [REG_AW-1:0] winRd;
    logic [XLEN-1:0]   winData;
    logic [2:0]        winWen;

    logic [2:0]        wenReg;
    logic [REG_AW-1:0] addrReg;
    logic [XLEN-1:0]   dataReg;
    logic              longReg;

    logic [NREG-1:0]   pendingReg;
    logic [NREG-1:0]   pendingNext;

    wb_rr_arb2 u_rr (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .block  (bus.alu_valid),
        .reqA   (bus.lsu_valid),
        .reqB   (bus.mdu_valid),
        .grantA (lsuGrant),
        .grantB (mduGrant)
    );

    assign bus.lsu_ready = lsuGrant;
    assign bus.mdu_ready = mduGrant;

    always_comb begin
        winValid = 1'b0;
        winLong  = 1'b0;
        winRd    = '0;
        winData  = '0;
        winWen   = WEN_NONE;
        if (bus.alu_valid) begin
            winValid = 1'b1;
            winRd    = bus.alu_rd;
            winData  = bus.alu_data;
            winWen   = WEN_W;
        end else if (lsuGrant) begin
            winValid = 1'b1;
            winLong  = 1'b1;
            winRd    = bus.lsu_rd;
            winData  = bus.lsu_data;
            winWen   = mapFmt(bus.lsu_fmt);
        end else if (mduGrant) begin
            winValid = 1'b1;
            winLong  = 1'b1;
            winRd    = bus.mdu_rd;
            winData  = bus.mdu_data;
            winWen   = WEN_W;
        end
        // x0 is hardwired: the handshake completes but nothing is written.
        if (winRd == '0) begin
            winWen = WEN_NONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wenReg  <= WEN_NONE;
            addrReg <= '0;
            dataReg <= '0;
            longReg <= 1'b0;
        end else begin
            wenReg <= winValid ? winWen : WEN_NONE;
            if (winValid) begin
                addrReg <= winRd;
                dataReg <= winData;
                longReg <= winLong;
            end
        end
    end

    assign bus.RegWEn       = wenReg;
    assign bus.WriteAddress = addrReg;
    assign bus.WriteData    = dataReg;

    // Clear retires with the register-file commit; a same-cycle issue wins.
    always_comb begin
        pendingNext = pendingReg;
        if (wenReg != WEN_NONE && longReg) begin
            pendingNext[addrReg] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) begin
            pendingNext[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            pendingReg <= '0;
        end else begin
            pendingReg <= pendingNext;
        end
    end

    assign bus.stall = bus.dec_valid & (pendingReg[bus.dec_rs1] |
                                        pendingReg[bus.dec_rs2] |
                                        pendingReg[bus.dec_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic CLK;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkWrite(input string tag, input logic [2:0] wen,
                              input logic [4:0] addr, input logic [31:0] data);
        check({tag, ".wen"},  32'(bus.RegWEn),       32'(wen));
        check({tag, ".addr"}, 32'(bus.WriteAddress), 32'(addr));
        check({tag, ".data"}, bus.WriteData,         data);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h2; bus.lsu_fmt = 3'b000;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'h3;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd3; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;

        // Reset held two cycles with every source active
        tick();
        tick();
        checkWrite("reset", 3'b000, 5'd0, 32'h0);
        check("reset.stall",   32'(bus.stall), 32'd0);
        check("reset.pending", dut.pendingReg, 32'h0);
        check("reset.lsu_rdy", 32'(bus.lsu_ready), 32'd0);

        // First ALU write after reset
        rst_n = 1'b1;
        bus.lsu_valid = 1'b0; bus.mdu_valid = 1'b0;
        bus.issue_valid = 1'b0; bus.dec_valid = 1'b0;
        bus.alu_rd = 5'd5; bus.alu_data = 32'h11;
        tick();
        bus.alu_valid = 1'b0;
        checkWrite("alu5", 3'b001, 5'd5, 32'h11);

        // Three-way contention: ALU first, then LSU, then MDU
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h22;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hAAAA; bus.lsu_fmt = 3'b011;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'hBBBB;
        #1;
        check("c1.lsu_rdy", 32'(bus.lsu_ready), 32'd0);
        check("c1.mdu_rdy", 32'(bus.mdu_ready), 32'd0);
        tick();
        bus.alu_valid = 1'b0;
        checkWrite("c1.wr", 3'b001, 5'd6, 32'h22);
        #1;
        check("c2.lsu_rdy", 32'(bus.lsu_ready), 32'd1);
        check("c2.mdu_rdy", 32'(bus.mdu_ready), 32'd0);
        tick();
        bus.lsu_valid = 1'b0;
        checkWrite("c2.wr", 3'b011, 5'd10, 32'hAAAA);
        #1;
        check("c3.mdu_rdy", 32'(bus.mdu_ready), 32'd1);
        tick();
        bus.mdu_valid = 1'b0;
        checkWrite("c3.wr", 3'b001, 5'd12, 32'hBBBB);
        tick();
        checkWrite("idle.hold", 3'b000, 5'd12, 32'hBBBB);

        // Scoreboard: issue rd=7, hazard on rs1, MDU retires at cycle N
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd7; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
        #1;
        check("sb.stall_issue", 32'(bus.stall), 32'd1);
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h77;
        #1;
        check("sb.mdu_rdy", 32'(bus.mdu_ready), 32'd1);
        check("sb.stall_N", 32'(bus.stall), 32'd1);
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        check("sb.stall_N1", 32'(bus.stall), 32'd1);
        checkWrite("sb.wr", 3'b001, 5'd7, 32'h77);
        tick();
        check("sb.stall_N2", 32'(bus.stall), 32'd0);
        bus.dec_valid = 1'b0;

        // rd=0 load completes handshake but does not write
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hDEAD; bus.lsu_fmt = 3'b010;
        #1;
        check("rd0.lsu_rdy", 32'(bus.lsu_ready), 32'd1);
        tick();
        check("rd0.wen", 32'(bus.RegWEn), 32'd0);
        // fmt 000 is written as a full word
        bus.lsu_rd = 5'd4; bus.lsu_data = 32'h44; bus.lsu_fmt = 3'b000;
        tick();
        bus.lsu_valid = 1'b0;
        checkWrite("fmt0", 3'b001, 5'd4, 32'h44);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
        #1;
        check("rd0.stall", 32'(bus.stall), 32'd0);
        bus.dec_valid = 1'b0;

        // ALU write to a pending register must not clear it
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd13;
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'h13;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd13;
        #1;
        check("alu.keep_pend", 32'(bus.stall), 32'd1);
        bus.dec_valid = 1'b0;

        // Same-cycle set and clear of rd=9: set wins
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h99;
        tick();
        bus.mdu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd9; bus.dec_rd = 5'd0;
        #1;
        check("sc.wen", 32'(bus.RegWEn), 32'd1);
        check("sc.stall_N1", 32'(bus.stall), 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("sc.stall_N2", 32'(bus.stall), 32'd1);
        check("sc.pend9", 32'(dut.pendingReg[9]), 32'd1);

        // Reset at the edge of an LSU grant drops the write and the scoreboard
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hCAFE; bus.lsu_fmt = 3'b001;
        rst_n = 1'b0;
        #1;
        check("mr.lsu_rdy", 32'(bus.lsu_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        bus.lsu_valid = 1'b0;
        check("mr.wen", 32'(bus.RegWEn), 32'd0);
        check("mr.pending", dut.pendingReg, 32'h0);
        check("mr.stall", 32'(bus.stall), 32'd0);
        bus.dec_valid = 1'b0;

        // Normal operation resumes after the mid-op reset
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h5;
        tick();
        bus.alu_valid = 1'b0;
        checkWrite("post_rst", 3'b001, 5'd1, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between three writeback sources: ALU, load/store unit (LSU) and multiply/divide unit (MDU).
- Registers the winning request onto RegWEn/WriteAddress/WriteData.
- Keeps a pending-write scoreboard for long-latency destinations and stalls decode on hazards against them.
- Sits between the execute/memory units and the register file.

Parameters:
- NREG, 32, number of architectural registers; index width is log2(NREG)=5
- XLEN, 32, data width

Ports:
- CLK  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result valid; always accepted, no ready
- alu_rd  in  5  ALU destination
- alu_data  in  32  ALU result
- lsu_valid  in  1  load result valid
- lsu_ready  out  1  load result accepted this cycle; combinational
- lsu_rd  in  5  load destination
- lsu_data  in  32  load data
- lsu_fmt  in  3  write format code passed to RegWEn; 3'b000 is treated as 3'b001
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  MDU result accepted this cycle; combinational
- mdu_rd  in  5  MDU destination
- mdu_data  in  32  MDU result
- issue_valid  in  1  decode issues an LSU load or MDU op this cycle
- issue_rd  in  5  destination of the issued op
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode operand and destination indices
- stall  out  1  decode must hold; combinational
- RegWEn  out  3  register file write enable/format; 0 means no write; registered
- WriteAddress  out  5  registered
- WriteData  out  32  registered

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - RegWEn=0, WriteAddress=0, WriteData=0.
  - pending[31:0]=0.
  - Round-robin pointer rr=0 (LSU favoured next).
  - Combinational outputs follow from the reset state: stall=0; lsu_ready/mdu_ready depend only on inputs.
  - Reset mid-operation drops any in-flight registered write (RegWEn=0 on the next cycle) and clears all pending bits.
- Arbitration, per cycle, combinational:
  - If alu_valid: ALU wins; lsu_ready=0, mdu_ready=0.
  - Otherwise, if exactly one of lsu_valid/mdu_valid is set: that source is granted.
  - Otherwise, if both are set: rr=0 grants LSU, rr=1 grants MDU.
  - After an LSU/MDU grant, rr points at the other source. ALU grants leave rr unchanged.
  - Readies may only assert when the matching valid is high.
- Write stage, registered, 1-cycle latency:
  - The winner at cycle N appears on RegWEn/WriteAddress/WriteData during cycle N+1. The register file commits it at the end of N+1.
  - RegWEn is 3'b001 for ALU and MDU, and lsu_fmt (000 mapped to 001) for LSU.
  - If the winner's rd==0, RegWEn=0 but the handshake still completes.
  - With no winner, RegWEn=0; WriteAddress/WriteData hold their previous values.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets pending[issue_rd] at the clock edge.
  - A write-stage entry from LSU or MDU with RegWEn!=0 clears pending[WriteAddress] at the end of cycle N+1, together with the register file commit. A per-entry source tag marks LSU/MDU entries.
  - Set and clear to the same index in the same cycle: set wins.
  - pending[0] is never set.
  - ALU writes never touch pending.
- stall = dec_valid & (pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]). The dec_rd term covers WAW hazards.
  - stall does not consider issue_valid in the same cycle; decode must not issue and depend on the same rd in one cycle.
  - No bypass: stall falls in cycle N+2 for a grant at cycle N.
- Sources hold valid/rd/data stable until ready. The arbiter must never grant two sources in one cycle.

Decomposition:
- Shared package holds:
  - Source encoding constants SRC_ALU=2'd0, SRC_LSU=2'd1, SRC_MDU=2'd2.
  - RegWEn format constants WEN_NONE=3'b000, WEN_W=3'b001, WEN_B=3'b010, WEN_H=3'b011, WEN_BU=3'b100, WEN_HU=3'b101.
  - XLEN and register index width.
- One natural sub-module, wb_rr_arb2: 2-way round-robin grant with the rr flop. The scoreboard stays inline.

Test Plan:
- Reset: hold rst_n=0 two cycles with all valids high -> RegWEn=0, stall=0, pending all 0. Release, then alu_valid rd=5 data=0x11 -> next cycle RegWEn=001, WriteAddress=5, WriteData=0x11.
- Contention: alu_valid, lsu_valid and mdu_valid all high for 3 cycles, with ALU dropping after cycle 1 -> cycle 1 ALU wins with both readies 0; cycle 2 LSU granted; cycle 3 MDU granted; write port shows the same order one cycle later.
- Scoreboard: issue_valid issue_rd=7, then dec_valid dec_rs1=7 -> stall=1. MDU returns rd=7 at cycle N -> stall stays 1 through N+1 and is 0 in N+2.
- rd=0: lsu_valid rd=0 fmt=010 -> lsu_ready=1, next cycle RegWEn=0. issue_rd=0 -> no stall on rs1=0.
- Simultaneous set/clear: MDU write of rd=9 in its write stage while issue_valid issue_rd=9 -> pending[9] remains 1 and stall persists for dec_rs2=9.
- Mid-op reset: lsu grant at N, rst_n=0 at the N edge -> RegWEn=0 in N+1 and pending cleared.
